// File: rtl/regfile_write_arbiter_if.sv
// Writeback bundle between the two result sources (ALU = s0, load = s1) and the write-port arbiter.
// Sources own valid/reg/data; the arbiter owns the ready grants.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              s0_valid;
  logic [ADDR_W-1:0] s0_reg;
  logic [DATA_W-1:0] s0_data;
  logic              s0_ready;
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_reg;
  logic [DATA_W-1:0] s1_data;
  logic              s1_ready;

  modport master (
    output s0_valid, s0_reg, s0_data, s1_valid, s1_reg, s1_data,
    input  s0_ready, s1_ready
  );

  modport slave (
    input  s0_valid, s0_reg, s0_data, s1_valid, s1_reg, s1_data,
    output s0_ready, s1_ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU/load writeback onto the single register-file write port (1-cycle registered port)
// and keeps a per-register busy scoreboard for RAW stalls; a stalled source is held off via ready.
module regfile_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  regfile_write_arbiter_if.slave wbIf,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_reg,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData
);

  localparam int NREG = 2**ADDR_W;

  logic              lastGrant;
  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] xferReg;
  logic [DATA_W-1:0] xferData;
  logic [NREG-1:0]   busyVec;
  logic [NREG-1:0]   busyNext;

  // lastGrant==0 means source 0 won most recently, so under contention source 1 is next.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!Reset) begin
      if (wbIf.s0_valid && wbIf.s1_valid) begin
        if (FIXED_PRIO || !lastGrant) grant1 = 1'b1;
        else                          grant0 = 1'b1;
      end else begin
        grant0 = wbIf.s0_valid;
        grant1 = wbIf.s1_valid;
      end
    end
  end

  assign wbIf.s0_ready = grant0;
  assign wbIf.s1_ready = grant1;
  assign xfer     = grant0 | grant1;
  assign xferReg  = grant1 ? wbIf.s1_reg  : wbIf.s0_reg;
  assign xferData = grant1 ? wbIf.s1_data : wbIf.s0_data;

  // Set after clear so a re-allocation racing the retiring write keeps the register busy.
  always_comb begin
    busyNext = busyVec;
    if (xfer) busyNext[xferReg] = 1'b0;
    if (alloc_valid && (alloc_reg != '0)) busyNext[alloc_reg] = 1'b1;
    if (flush) busyNext = '0;
  end

  assign rs_busy = busyVec[rs_addr];
  assign rt_busy = busyVec[rt_addr];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lastGrant     <= 1'b1;
      busyVec       <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      busyVec  <= busyNext;
      RegWrite <= xfer && (xferReg != '0);
      if (xfer) lastGrant <= grant1;
      if (xfer && (xferReg != '0)) begin
        WriteRegister <= xferReg;
        WriteData     <= xferData;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: a round-robin instance driven from a vector table, plus a fixed-priority
// instance and a same-register sequence exercised by hand.
module tb_regfile_write_arbiter;

  logic        Clk;
  logic        Reset;
  logic        alloc_valid;
  logic [4:0]  alloc_reg;
  logic        flush;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rrRsBusy, rrRtBusy, rrRegWrite;
  logic [4:0]  rrWriteRegister;
  logic [31:0] rrWriteData;
  logic        fxRsBusy, fxRtBusy, fxRegWrite;
  logic [4:0]  fxWriteRegister;
  logic [31:0] fxWriteData;

  int passCnt  = 0;
  int totalCnt = 0;

  regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) rrIf ();
  regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) fxIf ();

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(1'b0)) dutRr (
    .Clk(Clk), .Reset(Reset), .wbIf(rrIf),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg), .flush(flush),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rrRsBusy), .rt_busy(rrRtBusy),
    .RegWrite(rrRegWrite), .WriteRegister(rrWriteRegister), .WriteData(rrWriteData)
  );

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(1'b1)) dutFx (
    .Clk(Clk), .Reset(Reset), .wbIf(fxIf),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg), .flush(flush),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(fxRsBusy), .rt_busy(fxRtBusy),
    .RegWrite(fxRegWrite), .WriteRegister(fxWriteRegister), .WriteData(fxWriteData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        s0v;
    logic [4:0]  s0r;
    logic [31:0] s0d;
    logic        s1v;
    logic [4:0]  s1r;
    logic [31:0] s1d;
    logic        alc;
    logic [4:0]  alcReg;
    logic        fl;
    logic [4:0]  rs;
    logic        eS0;
    logic        eS1;
    logic        eBusy;
    logic        eRw;
    logic [4:0]  eWr;
    logic [31:0] eWd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rst, input logic s0v, input logic [4:0] s0r, input logic [31:0] s0d,
    input logic s1v, input logic [4:0] s1r, input logic [31:0] s1d,
    input logic alc, input logic [4:0] alcReg, input logic fl, input logic [4:0] rs,
    input logic eS0, input logic eS1, input logic eBusy,
    input logic eRw, input logic [4:0] eWr, input logic [31:0] eWd);
    vec_t v;
    v.rst = rst; v.s0v = s0v; v.s0r = s0r; v.s0d = s0d;
    v.s1v = s1v; v.s1r = s1r; v.s1d = s1d;
    v.alc = alc; v.alcReg = alcReg; v.fl = fl; v.rs = rs;
    v.eS0 = eS0; v.eS1 = eS1; v.eBusy = eBusy;
    v.eRw = eRw; v.eWr = eWr; v.eWd = eWd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic idleAll();
    rrIf.s0_valid = 0; rrIf.s0_reg = 0; rrIf.s0_data = 0;
    rrIf.s1_valid = 0; rrIf.s1_reg = 0; rrIf.s1_data = 0;
    fxIf.s0_valid = 0; fxIf.s0_reg = 0; fxIf.s0_data = 0;
    fxIf.s1_valid = 0; fxIf.s1_reg = 0; fxIf.s1_data = 0;
    alloc_valid = 0; alloc_reg = 0; flush = 0; rs_addr = 0; rt_addr = 0;
  endtask

  task automatic setFx(input logic s0v, input logic [4:0] s0r, input logic [31:0] s0d,
                       input logic s1v, input logic [4:0] s1r, input logic [31:0] s1d);
    fxIf.s0_valid = s0v; fxIf.s0_reg = s0r; fxIf.s0_data = s0d;
    fxIf.s1_valid = s1v; fxIf.s1_reg = s1r; fxIf.s1_data = s1d;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // rst s0v s0r s0d  s1v s1r s1d  alc reg fl rs | eS0 eS1 eBusy eRw eWr eWd
    tbl.push_back(mk(0,0,0,0,           0,0,0,     0,0,0,0,  0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,5,32'hDEADBEEF,0,0,0,     0,0,0,0,  1,0,0, 1,5,32'hDEADBEEF));
    tbl.push_back(mk(0,0,0,0,           0,0,0,     0,0,0,0,  0,0,0, 0,5,32'hDEADBEEF));
    tbl.push_back(mk(1,1,3,32'h11,      1,4,32'h22,0,0,0,0,  0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,3,32'h11,      1,4,32'h22,0,0,0,0,  1,0,0, 1,3,32'h11));
    tbl.push_back(mk(0,1,3,32'h11,      1,4,32'h22,0,0,0,0,  0,1,0, 1,4,32'h22));
    tbl.push_back(mk(0,1,3,32'h11,      1,4,32'h22,0,0,0,0,  1,0,0, 1,3,32'h11));
    tbl.push_back(mk(0,1,3,32'h11,      1,4,32'h22,0,0,0,0,  0,1,0, 1,4,32'h22));
    tbl.push_back(mk(0,0,0,0,           0,0,0,     1,7,0,7,  0,0,0, 0,4,32'h22));
    tbl.push_back(mk(0,0,0,0,           1,7,32'h77,0,0,0,7,  0,1,1, 1,7,32'h77));
    tbl.push_back(mk(0,1,7,32'h70,      0,0,0,     1,7,0,7,  1,0,0, 1,7,32'h70));
    tbl.push_back(mk(0,0,0,0,           0,0,0,     0,0,0,7,  0,0,1, 0,7,32'h70));
    tbl.push_back(mk(0,1,0,32'hFFFFFFFF,0,0,0,     1,0,0,0,  1,0,0, 0,7,32'h70));
    tbl.push_back(mk(0,0,0,0,           0,0,0,     1,1,0,0,  0,0,0, 0,7,32'h70));
    tbl.push_back(mk(0,0,0,0,           0,0,0,     1,2,0,1,  0,0,1, 0,7,32'h70));
    tbl.push_back(mk(0,0,0,0,           0,0,0,     1,3,0,2,  0,0,1, 0,7,32'h70));
    tbl.push_back(mk(0,0,0,0,           1,9,32'h99,1,5,1,3,  0,1,1, 1,9,32'h99));
    tbl.push_back(mk(0,0,0,0,           0,0,0,     0,0,0,1,  0,0,0, 0,9,32'h99));
    tbl.push_back(mk(0,0,0,0,           0,0,0,     0,0,0,3,  0,0,0, 0,9,32'h99));
    tbl.push_back(mk(0,0,0,0,           0,0,0,     0,0,0,5,  0,0,0, 0,9,32'h99));
    tbl.push_back(mk(0,0,0,0,           0,0,0,     1,8,0,7,  0,0,0, 0,9,32'h99));
    tbl.push_back(mk(1,1,3,32'h11,      1,4,32'h22,0,0,0,8,  0,0,1, 0,0,0));
    tbl.push_back(mk(0,0,0,0,           0,0,0,     0,0,0,8,  0,0,0, 0,0,0));

    idleAll();
    Reset = 1'b1;
    tick();
    tick();
    chk("reset RegWrite", {31'b0, rrRegWrite}, 0);
    chk("reset WriteData", rrWriteData, 0);
    Reset = 1'b0;

    foreach (tbl[i]) begin
      Reset         = tbl[i].rst;
      rrIf.s0_valid = tbl[i].s0v; rrIf.s0_reg = tbl[i].s0r; rrIf.s0_data = tbl[i].s0d;
      rrIf.s1_valid = tbl[i].s1v; rrIf.s1_reg = tbl[i].s1r; rrIf.s1_data = tbl[i].s1d;
      alloc_valid   = tbl[i].alc; alloc_reg = tbl[i].alcReg; flush = tbl[i].fl;
      rs_addr       = tbl[i].rs;  rt_addr = tbl[i].rs;
      #2;
      chk($sformatf("v%0d s0_ready", i), {31'b0, rrIf.s0_ready}, {31'b0, tbl[i].eS0});
      chk($sformatf("v%0d s1_ready", i), {31'b0, rrIf.s1_ready}, {31'b0, tbl[i].eS1});
      chk($sformatf("v%0d rs_busy", i),  {31'b0, rrRsBusy},      {31'b0, tbl[i].eBusy});
      chk($sformatf("v%0d rt_busy", i),  {31'b0, rrRtBusy},      {31'b0, tbl[i].eBusy});
      tick();
      chk($sformatf("v%0d RegWrite", i),      {31'b0, rrRegWrite},     {31'b0, tbl[i].eRw});
      chk($sformatf("v%0d WriteRegister", i), {27'b0, rrWriteRegister}, {27'b0, tbl[i].eWr});
      chk($sformatf("v%0d WriteData", i),     rrWriteData,             tbl[i].eWd);
    end

    // Fixed priority: load source wins every contended cycle, ALU gets through once load drops.
    idleAll();
    Reset = 1'b0;
    setFx(1, 3, 32'h11, 1, 4, 32'h22);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("fx c%0d s1_ready", c), {31'b0, fxIf.s1_ready}, 1);
      chk($sformatf("fx c%0d s0_ready", c), {31'b0, fxIf.s0_ready}, 0);
      tick();
      chk($sformatf("fx c%0d WriteRegister", c), {27'b0, fxWriteRegister}, 4);
      chk($sformatf("fx c%0d WriteData", c), fxWriteData, 32'h22);
    end
    setFx(1, 3, 32'h11, 0, 0, 0);
    #2;
    chk("fx s0 ready after load drops", {31'b0, fxIf.s0_ready}, 1);
    tick();
    chk("fx s0 RegWrite", {31'b0, fxRegWrite}, 1);
    chk("fx s0 WriteRegister", {27'b0, fxWriteRegister}, 3);
    chk("fx s0 WriteData", fxWriteData, 32'h11);

    // Reset while both sources are requesting.
    setFx(1, 3, 32'h11, 1, 4, 32'h22);
    Reset = 1'b1;
    #2;
    chk("fx reset s0_ready", {31'b0, fxIf.s0_ready}, 0);
    chk("fx reset s1_ready", {31'b0, fxIf.s1_ready}, 0);
    tick();
    chk("fx reset RegWrite", {31'b0, fxRegWrite}, 0);
    chk("fx reset WriteRegister", {27'b0, fxWriteRegister}, 0);
    chk("fx reset WriteData", fxWriteData, 0);
    Reset = 1'b0;
    setFx(0, 0, 0, 0, 0, 0);

    // Both sources target reg 6 back-to-back: ALU first after reset, load data lands last.
    rrIf.s0_valid = 1; rrIf.s0_reg = 6; rrIf.s0_data = 32'hA;
    rrIf.s1_valid = 1; rrIf.s1_reg = 6; rrIf.s1_data = 32'hB;
    #2;
    chk("same-reg first grant s0", {31'b0, rrIf.s0_ready}, 1);
    tick();
    rrIf.s0_valid = 0;
    chk("same-reg first WriteData", rrWriteData, 32'hA);
    #2;
    chk("same-reg second grant s1", {31'b0, rrIf.s1_ready}, 1);
    tick();
    rrIf.s1_valid = 0;
    chk("same-reg second WriteRegister", {27'b0, rrWriteRegister}, 6);
    chk("same-reg second WriteData", rrWriteData, 32'hB);
    tick();
    chk("same-reg idle RegWrite", {31'b0, rrRegWrite}, 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
